// File: rtl/serial_pair_pkg.sv
// Shared types and constants for the x/y serial pair: transmitter FSM states,
// default operand width, counter sizing and the comparator result codes.
package serial_pair_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLR   = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Comparator `out` codes, shared with the downstream comparator and benches.
  localparam logic [1:0] CMP_EQ = 2'b00;
  localparam logic [1:0] CMP_GT = 2'b01;
  localparam logic [1:0] CMP_LT = 2'b10;

  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_pair_tx_if.sv
// Load handshake and serial output bundle of serial_pair_tx.
// Handshake: a word transfers on a rising edge where load_valid && load_ready;
// load_ready never depends on load_valid, and an unaccepted offer is simply dropped.
interface serial_pair_tx_if #(
  parameter int WIDTH = serial_pair_pkg::DEFAULT_WIDTH
);
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             load_valid;
  logic             load_ready;
  logic             x;
  logic             y;
  logic             clr;
  logic             frame;
  logic             last;
  logic             done;

  modport master (
    output a_in, b_in, load_valid,
    input  load_ready, x, y, clr, frame, last, done
  );

  modport slave (
    input  a_in, b_in, load_valid,
    output load_ready, x, y, clr, frame, last, done
  );
endinterface

// File: rtl/piso_shift.sv
// Parallel-in/serial-out register. Direction: MSB-first by default, LSB-first
// when SERIAL_PAIR_TX_LSB_FIRST_EN is defined. Load has priority over shift.
module piso_shift #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_bit
);

  logic [WIDTH-1:0] r_sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sr <= '0;
    end else if (i_load) begin
      r_sr <= i_data;
    end else if (i_shift) begin
`ifdef SERIAL_PAIR_TX_LSB_FIRST_EN
      r_sr <= {1'b0, r_sr[WIDTH-1:1]};
`else
      r_sr <= {r_sr[WIDTH-2:0], 1'b0};
`endif
    end
  end

`ifdef SERIAL_PAIR_TX_LSB_FIRST_EN
  assign o_bit = r_sr[0];
`else
  assign o_bit = r_sr[WIDTH-1];
`endif

endmodule

// File: rtl/serial_pair_tx.sv
// Transmit end of the x/y serial pair: accepts two operands, pulses clr, then
// shifts both out in lockstep with frame/last/done. Bit order: SERIAL_PAIR_TX_LSB_FIRST_EN.
module serial_pair_tx
  import serial_pair_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  serial_pair_tx_if.slave   bus,
  output state_t            o_dbg_state
);

  localparam int CW = cnt_width(WIDTH);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_accept;
  logic          w_shift;
  logic          w_a_bit;
  logic          w_b_bit;
  logic          r_x;
  logic          r_y;
  logic          r_clr;
  logic          r_frame;
  logic          r_last;
  logic          r_done;

  assign w_accept = bus.load_valid && (r_state == ST_IDLE);
  // Every edge that lands in SHIFT consumes one bit from each shift register.
  assign w_shift  = (w_state_nxt == ST_SHIFT);

  piso_shift #(.WIDTH(WIDTH)) u_piso_a (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_accept),
    .i_shift (w_shift),
    .i_data  (bus.a_in),
    .o_bit   (w_a_bit)
  );

  piso_shift #(.WIDTH(WIDTH)) u_piso_b (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_accept),
    .i_shift (w_shift),
    .i_data  (bus.b_in),
    .o_bit   (w_b_bit)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_CLR;
          w_cnt_nxt   = CW'(WIDTH - 1);
        end
      end
      ST_CLR: begin
        w_state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Outputs are registered from the next-state view so they line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x     <= 1'b0;
      r_y     <= 1'b0;
      r_clr   <= 1'b0;
      r_frame <= 1'b0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_x     <= w_shift & w_a_bit;
      r_y     <= w_shift & w_b_bit;
      r_clr   <= (w_state_nxt == ST_CLR);
      r_frame <= w_shift;
      r_last  <= w_shift && (w_cnt_nxt == '0);
      r_done  <= (r_state == ST_SHIFT) && (w_state_nxt == ST_IDLE);
    end
  end

  assign bus.load_ready = (r_state == ST_IDLE);
  assign bus.x          = r_x;
  assign bus.y          = r_y;
  assign bus.clr        = r_clr;
  assign bus.frame      = r_frame;
  assign bus.last       = r_last;
  assign bus.done       = r_done;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_serial_pair_tx.sv
// Self-checking bench for serial_pair_tx: word-level timing model checked every
// cycle, plus literal word checks. Honours SERIAL_PAIR_TX_LSB_FIRST_EN.
module tb_serial_pair_tx;
  import serial_pair_pkg::*;

  localparam int W = 8;

  logic   clk;
  logic   rst;
  state_t dbg_state;
  int     checks;
  int     failures;

  serial_pair_tx_if #(.WIDTH(W)) bus ();

  serial_pair_tx #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model: word accepted at edge m_t ----------------
  int          edge_cnt = 0;
  bit          m_active = 0;
  int          m_t      = 0;
  logic [W-1:0] m_a, m_b;

  function automatic int bidx(input int i);
`ifdef SERIAL_PAIR_TX_LSB_FIRST_EN
    return i;
`else
    return W - 1 - i;
`endif
  endfunction

  always @(posedge clk) begin
    int  d_end;
    bit  rdy;
    d_end = edge_cnt - m_t + 1;
    rdy   = !m_active || (d_end >= W + 2);
    edge_cnt = edge_cnt + 1;
    if (rst) begin
      m_active = 0;
    end else if (bus.load_valid && rdy) begin
      m_active = 1;
      m_t      = edge_cnt;
      m_a      = bus.a_in;
      m_b      = bus.b_in;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare against the model ----------------
  always @(negedge clk) begin
    int   d;
    logic e_ready, e_clr, e_frame, e_x, e_y, e_last, e_done;
    d = edge_cnt - m_t + 1;
    if (rst || !m_active) begin
      e_ready = 1; e_clr = 0; e_frame = 0; e_x = 0; e_y = 0; e_last = 0; e_done = 0;
    end else begin
      e_ready = (d >= W + 2);
      e_clr   = (d == 1);
      e_frame = (d >= 2) && (d <= W + 1);
      e_x     = e_frame ? m_a[bidx(e_frame ? d - 2 : 0)] : 1'b0;
      e_y     = e_frame ? m_b[bidx(e_frame ? d - 2 : 0)] : 1'b0;
      e_last  = (d == W + 1);
      e_done  = (d == W + 2);
    end
    chk("cyc_load_ready", bus.load_ready, e_ready);
    chk("cyc_clr",        bus.clr,        e_clr);
    chk("cyc_frame",      bus.frame,      e_frame);
    chk("cyc_x",          bus.x,          e_x);
    chk("cyc_y",          bus.y,          e_y);
    chk("cyc_last",       bus.last,       e_last);
    chk("cyc_done",       bus.done,       e_done);
  end

  // ---------------- scoreboard of words accepted by directed sends ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_y_q[$];

  // Call at negedge+1; returns just after the accepting rising edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    bit acc;
    int n;
    acc = 0;
    n   = 0;
    bus.a_in = a;
    bus.b_in = b;
    bus.load_valid = 1'b1;
    while (!acc && n < 50) begin
      acc = bus.load_ready;
      @(posedge clk);
      if (!acc) begin
        @(negedge clk);
        #1;
      end
      n++;
    end
    chk("send_accepted", acc, 1'b1);
    if (acc) begin
      exp_q.push_back(a);
      exp_y_q.push_back(b);
    end
  endtask

  // Follows a word from its clr cycle to its done cycle; ends at negedge+1 of the done cycle.
  task automatic collect_word(input string tag, input bit hold);
    logic [W-1:0] xa, yb, ea, eb;
    xa = '0;
    yb = '0;
    @(negedge clk);
    #1;
    bus.load_valid = hold;
    chk({tag, "_clr"}, bus.clr, 1'b1);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      xa[bidx(i)] = bus.x;
      yb[bidx(i)] = bus.y;
      chk({tag, "_last"}, bus.last, (i == W - 1) ? 1'b1 : 1'b0);
      #1;
      if (hold) begin
        bus.load_valid = (i != W - 1);
        bus.a_in = W'($urandom);
        bus.b_in = W'($urandom);
      end
    end
    @(negedge clk);
    #1;
    chk({tag, "_done"}, bus.done, 1'b1);
    chk({tag, "_q_nonempty"}, (exp_q.size() > 0) ? 1 : 0, 1);
    if (exp_q.size() > 0) begin
      ea = exp_q.pop_front();
      eb = exp_y_q.pop_front();
      chk({tag, "_x_word"}, xa, ea);
      chk({tag, "_y_word"}, yb, eb);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=running expected=finished t=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus.load_valid = 1'b0;
    bus.a_in = '0;
    bus.b_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;

    // reset state with no load offered
    @(negedge clk);
    #1;
    chk("rst_load_ready", bus.load_ready, 1'b1);
    chk("rst_outputs", {bus.x, bus.y, bus.clr, bus.frame, bus.last, bus.done}, 6'b0);

    // A5/3C then back-to-back FF/00 accepted in the done cycle
    send(8'hA5, 8'h3C);
    collect_word("w_a5", 1'b0);
    send(8'hFF, 8'h00);
    collect_word("w_ff_b2b", 1'b0);
    bus.load_valid = 1'b0;

    // load_valid held with changing a_in/b_in while a word is in flight
    @(negedge clk);
    #1;
    send(8'hC3, 8'h5A);
    collect_word("w_hold", 1'b1);
    bus.load_valid = 1'b0;

    // reset pulsed during bit 4 of a word
    @(negedge clk);
    #1;
    send(8'h5A, 8'h96);
    void'(exp_q.pop_back());
    void'(exp_y_q.pop_back());
    @(negedge clk);
    #1;
    bus.load_valid = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    chk("pre_rst_frame", bus.frame, 1'b1);
    rst = 1'b1;
    #1;
    chk("async_rst_outputs", {bus.x, bus.y, bus.clr, bus.frame, bus.last, bus.done}, 6'b0);
    chk("async_rst_ready", bus.load_ready, 1'b1);
    @(negedge clk);
    #1;
    rst = 1'b0;
    repeat (12) @(negedge clk);
    #1;
    send(8'h01, 8'h80);
    collect_word("w_after_rst", 1'b0);
    send(8'hA5, 8'h3C);
    collect_word("w_a5_again", 1'b0);
    bus.load_valid = 1'b0;

    // random offers, data and occasional resets, checked by the per-cycle model
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      #1;
      rst = ($urandom_range(0, 79) == 0);
      bus.load_valid = ($urandom_range(0, 2) != 0);
      bus.a_in = W'($urandom);
      bus.b_in = W'($urandom);
    end
    @(negedge clk);
    #1;
    rst = 1'b0;
    bus.load_valid = 1'b0;
    repeat (W + 4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
